// File: rtl/tx_frame_ctrl.sv
// tx_frame_ctrl: UART transmit frame sequencer that sits beside the TX serializer.
// It frames each word as start bit, WIDTH data bits (LSB first), optional parity
// bit and stop bit. It drives the serializer shift enable, the line-mux select,
// the BUSY/accept handshake, the final TX line level and a stop-bit TX_DONE pulse.
//
// Optional feature, macro TX_BACK_TO_BACK_EN: when defined, BUSY drops during the
// stop bit so a pending word is accepted there and the next start bit follows the
// stop bit with no idle gap. When undefined, at least one IDLE cycle separates frames.
module tx_frame_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] P_DATA,
    input  logic             DATA_VALID,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    input  logic             SER_DATA,
    input  logic             SER_DONE,
    output logic             SER_ENABLE,
    output logic [1:0]       MUX_SEL,
    output logic             BUSY,
    output logic             TX_OUT,
    output logic             TX_DONE
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] SEL_START  = 2'b00;
    localparam logic [1:0] SEL_STOP   = 2'b01;
    localparam logic [1:0] SEL_DATA   = 2'b10;
    localparam logic [1:0] SEL_PARITY = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_data;
    logic             r_par_en;
    logic             r_par_typ;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_par_bit;
    logic             w_wd_expire;

    // A word is taken whenever the source offers one and the frame handshake is free.
    assign w_accept    = DATA_VALID && !BUSY;
    // Parity is computed only from the latched copy so mid-frame input changes are harmless.
    assign w_par_bit   = (^r_data) ^ r_par_typ;
    // Last permitted DATA cycle: without SER_DONE by now the frame is forced to STOP.
    assign w_wd_expire = (r_cnt == CW'(WIDTH - 1));

    // State register; reset aborts any frame in progress.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latched frame attributes, captured on the accept edge only.
    always_ff @(posedge CLK) begin
        // NOTE: the word and parity latches are reset too, so parity is defined
        // even before the first frame rather than carrying X into PARITY decode.
        if (RST) begin
            r_data    <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
        end else if (w_accept) begin
            r_data    <= P_DATA;
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
        end
    end

    // DATA-phase cycle counter feeding the watchdog; idles at zero outside DATA.
    always_ff @(posedge CLK) begin
        if (RST || (r_state != S_DATA)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Next-state logic; unused encodings fall back to IDLE.
    always_comb begin
        // NOTE: a default is assigned first so every path drives w_next and no
        // latch is inferred.
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:   w_next = w_accept ? S_START : S_IDLE;
            S_START:  w_next = S_DATA;
            S_DATA: begin
                if (SER_DONE) begin
                    w_next = r_par_en ? S_PARITY : S_STOP;
                end else if (w_wd_expire) begin
                    w_next = S_STOP;
                end else begin
                    w_next = S_DATA;
                end
            end
            S_PARITY: w_next = S_STOP;
            S_STOP:   w_next = w_accept ? S_START : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Control outputs decoded from the current state.
    always_comb begin
        SER_ENABLE = 1'b0;
        MUX_SEL    = SEL_STOP;
        BUSY       = 1'b0;
        TX_DONE    = 1'b0;
        case (r_state)
            S_IDLE: begin
                BUSY = 1'b0;
            end
            S_START: begin
                BUSY    = 1'b1;
                MUX_SEL = SEL_START;
            end
            S_DATA: begin
                BUSY       = 1'b1;
                SER_ENABLE = 1'b1;
                MUX_SEL    = SEL_DATA;
            end
            S_PARITY: begin
                BUSY    = 1'b1;
                MUX_SEL = SEL_PARITY;
            end
            S_STOP: begin
                TX_DONE = 1'b1;
`ifdef TX_BACK_TO_BACK_EN
                BUSY    = 1'b0;
`else
                BUSY    = 1'b1;
`endif
            end
            default: begin
                // Hold off the serializer while recovering from a stray encoding.
                BUSY = 1'b1;
            end
        endcase
    end

    // Line multiplexer: start, stop/idle, serializer data or parity.
    always_comb begin
        TX_OUT = 1'b1;
        case (MUX_SEL)
            SEL_START:  TX_OUT = 1'b0;
            SEL_STOP:   TX_OUT = 1'b1;
            SEL_DATA:   TX_OUT = SER_DATA;
            SEL_PARITY: TX_OUT = w_par_bit;
            default:    TX_OUT = 1'b1;
        endcase
    end

endmodule
